// File: rtl/ls_pkg.sv
// Shared types and helpers for the load/store sequencer: FSM states, funct3
// encodings, access size and legality checks.
package ls_pkg;

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WRITE, DONE} ls_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  function automatic logic [3:0] size_of(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 4'd1;
      2'b01:   return 4'd2;
      2'b10:   return 4'd4;
      default: return 4'd8;
    endcase
  endfunction

  // Legal funct3 for the direction, and naturally aligned for its size.
  function automatic logic access_ok(input logic st, input logic [2:0] f3,
                                     input logic [2:0] off);
    logic [2:0] amask;
    amask = 3'(size_of(f3) - 4'd1);
    if (st ? f3[2] : (f3 == 3'b111)) return 1'b0;
    return (off & amask) == 3'b000;
  endfunction

endpackage

// File: rtl/ls_byte_lane.sv
// Combinational byte-lane logic: extracts/extends load data from a doubleword
// and merges narrow store data into a doubleword for read-modify-write.
module ls_byte_lane
  import ls_pkg::*;
(
  input  logic [63:0] dq_i,
  input  logic [63:0] wdata_i,
  input  logic [2:0]  off_i,
  input  logic [2:0]  funct3_i,
  output logic [63:0] load_o,
  output logic [63:0] store_o
);

  logic [63:0] sh;
  logic [63:0] wsh;
  logic [63:0] bmask;
  logic [63:0] msh;

  assign sh  = dq_i >> {off_i, 3'b000};
  assign wsh = wdata_i << {off_i, 3'b000};
  assign msh = bmask << {off_i, 3'b000};

  always_comb begin
    case (funct3_i)
      F3_B:    load_o = {{56{sh[7]}}, sh[7:0]};
      F3_H:    load_o = {{48{sh[15]}}, sh[15:0]};
      F3_W:    load_o = {{32{sh[31]}}, sh[31:0]};
      F3_BU:   load_o = {56'b0, sh[7:0]};
      F3_HU:   load_o = {48'b0, sh[15:0]};
      F3_WU:   load_o = {32'b0, sh[31:0]};
      default: load_o = sh;
    endcase
  end

  always_comb begin
    case (funct3_i[1:0])
      2'b00:   bmask = 64'h0000_0000_0000_00FF;
      2'b01:   bmask = 64'h0000_0000_0000_FFFF;
      2'b10:   bmask = 64'h0000_0000_FFFF_FFFF;
      default: bmask = '1;
    endcase
  end

  assign store_o = (dq_i & ~msh) | (wsh & msh);

endmodule

// File: rtl/ls_sequencer.sv
// Multicycle RV64 load/store sequencer in front of a doubleword-wide memory.
// Narrow stores are read-modify-write; all outputs are registered.
module ls_sequencer
  import ls_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [63:0] addr,
  input  logic [63:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [63:0] rdata,
  output logic [63:0] mem_addr,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [63:0] mem_wdata,
  input  logic [63:0] mem_rdata
);

  localparam int CW = $clog2(MEM_LAT) + 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(MEM_LAT - 1);

  ls_state_t   state_q;
  logic        st_q;
  logic [2:0]  f3_q;
  logic [63:0] addr_q, wdata_q, dq_q, dq_d;
  logic [CW-1:0] cnt_q;
  logic        busy_q, done_q, err_q, mem_rd_q, mem_wr_q;
  logic [63:0] rdata_q, mem_wdata_q;
  logic [63:0] ld_val, st_val;
  logic        rd_hit;

  // The lane logic sees memory data in the capture cycle so that the load
  // result and the merged store word are registered on the same edge.
  assign rd_hit = (state_q == RD_WAIT) && (cnt_q == '0);
  assign dq_d   = rd_hit ? mem_rdata : dq_q;

  ls_byte_lane u_lane (
    .dq_i     (dq_d),
    .wdata_i  (wdata_q),
    .off_i    (addr_q[2:0]),
    .funct3_i (f3_q),
    .load_o   (ld_val),
    .store_o  (st_val)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      st_q        <= 1'b0;
      f3_q        <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      dq_q        <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      rdata_q     <= '0;
      mem_wdata_q <= '0;
    end else begin
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      mem_rd_q <= 1'b0;
      mem_wr_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          st_q    <= is_store;
          f3_q    <= funct3;
          addr_q  <= addr;
          wdata_q <= wdata;
          busy_q  <= 1'b1;
          if (!access_ok(is_store, funct3, addr[2:0])) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
            rdata_q <= '0;
          end else if (is_store && funct3 == F3_D) begin
            state_q     <= WRITE;
            mem_wr_q    <= 1'b1;
            mem_wdata_q <= wdata;
          end else begin
            state_q  <= RD_REQ;
            mem_rd_q <= 1'b1;
          end
        end
        RD_REQ: begin
          cnt_q   <= CNT_INIT;
          state_q <= RD_WAIT;
        end
        RD_WAIT: begin
          if (rd_hit) begin
            dq_q <= mem_rdata;
            if (st_q) begin
              state_q     <= WRITE;
              mem_wr_q    <= 1'b1;
              mem_wdata_q <= st_val;
            end else begin
              state_q <= DONE;
              done_q  <= 1'b1;
              rdata_q <= ld_val;
            end
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        WRITE: begin
          state_q <= DONE;
          done_q  <= 1'b1;
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign rdata     = rdata_q;
  assign mem_rd    = mem_rd_q;
  assign mem_wr    = mem_wr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_addr  = {addr_q[63:3], 3'b000};

endmodule

// File: doc/ls_sequencer.md
# ls_sequencer

Multicycle load/store sequencer between the main control FSM and a 64-bit doubleword-wide data memory. It accepts one RV64 load or store per `start` and runs the memory handshake. Sub-doubleword stores use read-modify-write. Load results are byte-lane extracted and sign- or zero-extended. The control FSM waits on `done` instead of hard-coding memory states.

## Interface
Parameters:
- `MEM_LAT`, default 1: memory read latency in cycles (≥1). `mem_rdata` is valid `MEM_LAT` cycles after the `mem_rd` cycle.

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-high
- `start`  in  1  request strobe; sampled only in IDLE
- `is_store`  in  1  1 = store, 0 = load
- `funct3`  in  3  RISC-V funct3. Loads: 000 lb, 001 lh, 010 lw, 011 ld, 100 lbu, 101 lhu, 110 lwu. Stores: 000 sb, 001 sh, 010 sw, 011 sd
- `addr`  in  64  byte address (from AluOut)
- `wdata`  in  64  store data (from RegB); low bytes used for narrow stores
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle completion pulse
- `err`  out  1  valid with `done`; misaligned access or illegal funct3
- `rdata`  out  64  extended load result; held until next `done`
- `mem_addr`  out  64  `{addr_q[63:3], 3'b000}`
- `mem_rd`  out  1  read strobe, one cycle
- `mem_wr`  out  1  write strobe, one cycle
- `mem_wdata`  out  64  full doubleword to write
- `mem_rdata`  in  64  memory read data

## Operation
- States: IDLE, RD_REQ, RD_WAIT, WRITE, DONE.
- **IDLE, `start`=1:** latch `is_store`, `funct3`, `addr`, `wdata`. Then select the next state:
  - Illegal or misaligned access → DONE with `err`=1.
  - `sd` → WRITE.
  - Any other legal access → RD_REQ.
- **Illegal funct3:** load 111; store 1xx.
- **Misaligned:** h with `addr[0]`≠0; w with `addr[1:0]`≠0; d with `addr[2:0]`≠0.
- **RD_REQ:** `mem_rd`=1. Load counter with `MEM_LAT-1`. Go to RD_WAIT.
- **RD_WAIT:** decrement the counter. At zero, capture `mem_rdata` into `dq`.
  - Load → DONE.
  - Store → WRITE.
- **WRITE:** `mem_wr`=1. `mem_wdata` = `wdata_q` for sd. For narrow stores it is `dq` with lanes `addr_q[2:0]`..+size-1 replaced by the low bytes of `wdata_q`. Go to DONE.
- **DONE:** `done`=1, `busy`=1. `rdata` is updated in the transition into DONE (register). Go to IDLE.
- **Load extraction:** little-endian. Byte lane = `addr_q[2:0]`. lb/lh/lw sign-extend from bit 7/15/31; lbu/lhu/lwu zero-extend; ld passes through.
- **On error:** `rdata`=0, no `mem_rd`/`mem_wr` issued.
- **Stores:** `rdata` is unchanged.
- `start` is ignored in all non-IDLE states, including DONE. No queuing.
- `mem_addr` is driven from `addr_q` in every state (0 in IDLE after reset).

## Timing
- **Reset values:** state IDLE; `busy`, `done`, `err`, `mem_rd`, `mem_wr` = 0; `rdata`, `mem_wdata`, `mem_addr` = 0; internal regs = 0.
- **Reset mid-operation:** immediate return to IDLE. Strobes drop asynchronously. No partial write is issued after reset.
- **Latency from `start` in cycle T** (`done` cycle, L = `MEM_LAT`):
  - load: T+2+L
  - sd: T+2
  - narrow store: T+3+L
  - error: T+1
- **L=1:** load `done` at T+3; sb `done` at T+4.
- **Back-to-back:** the next `start` is accepted in the IDLE cycle after DONE, so minimum spacing is latency+1.
- `mem_rd` and `mem_wr` are never high in the same cycle. Each is exactly one cycle per access.

## Structure
- **Package `ls_pkg`:**
  - `ls_state_t` enum.
  - funct3 constants `F3_B`, `F3_H`, `F3_W`, `F3_D`, `F3_BU`, `F3_HU`, `F3_WU`.
  - `size_of(funct3)` function returning 1/2/4/8.
- **Sub-module `ls_byte_lane`:** purely combinational.
  - Inputs: `dq`, `wdata_q`, `addr_q[2:0]`, `funct3`.
  - Outputs: extracted/extended load value and merged store doubleword.
- **Top:** FSM, latency counter (width `$clog2(MEM_LAT)+1`) and operand registers.

## Test plan
- **lb sign-extension:** `mem_rdata`=0x8877_6655_4433_2211 at `addr`=0x1007, L=1 → `done` at T+3, `rdata`=0xFFFF_FFFF_FFFF_FF88, `err`=0, `mem_addr`=0x1000.
- **lhu / lwu:** same data, lhu at 0x1002 → `rdata`=0x4433; lwu at 0x1004 → 0x8877_6655.
- **sb read-modify-write:** sb `wdata`=0xAB at 0x2003 over memory 0x0 → one `mem_rd`, then one `mem_wr` with `mem_wdata`=0x0000_0000_AB00_0000, `done` at T+4.
- **sd direct write:** sd at 0x2008 → no `mem_rd`; `mem_wr` at T+1; `done` at T+2.
- **Error paths:** lw at 0x1002, or load funct3=111 → `done` at T+1 with `err`=1, `rdata`=0, no memory strobes.
- **Latency, overlap and reset:** with `MEM_LAT`=3, ld `done` arrives at T+5, and `start` pulses while busy are ignored. Asserting `rst` during RD_WAIT returns to IDLE with all outputs 0 and no subsequent `mem_wr`.
